alu_seq: RTL and testbench



---
 rtl/alu_seq_pkg.sv | 36 +++
 rtl/alu_seq_mul.sv | 81 ++++++++
 rtl/alu_seq.sv | 182 ++++++++++++++++++
 tb/tb_alu_seq.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared types for the registered ALU (alu_seq): function-code
//               enum, FSM state enum and the status-flag bundle.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

  typedef enum logic [2:0] {
    F_AND  = 3'b000,
    F_OR   = 3'b001,
    F_ADD  = 3'b010,
    F_MUL  = 3'b011,
    F_XOR  = 3'b100,
    F_SLTU = 3'b101,
    F_SUB  = 3'b110,
    F_SLT  = 3'b111
  } func_e;

  typedef enum logic [0:0] {
    S_IDLE     = 1'b0,
    S_MUL_BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
    logic err;
  } flags_t;

endpackage
`default_nettype wire

// File: rtl/alu_seq_mul.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_mul
// Description : Iterative shift-add multiplier, one partial product per clock.
//               Returns the low WIDTH bits of a*b (sign-agnostic).
//               A start pulse loads the operands; done is high during the
//               last iteration and product already includes that final
//               partial product, so the caller registers it on that edge.
// Ports       : clk, rst_n (async, active-low), start, a, b  -> done, product
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_mul
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             busy_q,   busy_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [WIDTH-1:0] acc_next;

  // Accumulator after adding this cycle's partial product.
  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done     = busy_q && (cnt_q == '0);
  assign product  = acc_next;

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = CNT_W'(WIDTH - 1);
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
    end else if (busy_q) begin
      acc_d    = acc_next;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        cnt_d  = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Registered ALU with valid/ready handshakes on both sides,
//               backpressure-safe output register and status flags.
//               Optional iterative multiplier for code 011, enabled by the
//               macro ALU_SEQ_MUL_EN; without it code 011 is illegal.
// Ports       : clk, rst_n (async, active-low)
//               in_valid/in_ready, a, b, f       - operation input
//               out_valid/out_ready, out         - registered result
//               zero, neg, carry, ovf, err       - registered flags
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic             err
);

  state_e           state_q, state_d;
  logic             rdy_arm_q, rdy_arm_d;
  logic [WIDTH-1:0] out_q, out_d;
  flags_t           flags_q, flags_d;
  logic             out_valid_q, out_valid_d;

  func_e            fc;
  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_p;

  logic             sub_mode;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum_full;
  logic [WIDTH-1:0] sum;
  logic             add_ovf;
  logic [WIDTH-1:0] alu_res;
  flags_t           alu_flags;

  assign fc     = func_e'(f);
  assign accept = in_valid && in_ready;

  // ---------------------------------------------------------------- datapath
  // One adder serves ADD, SUB, SLT and SLTU; the compares reuse a - b.
  assign sub_mode = (fc == F_SUB) || (fc == F_SLT) || (fc == F_SLTU);
  assign b_op     = sub_mode ? ~b : b;
  assign sum_full = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub_mode};
  assign sum      = sum_full[WIDTH-1:0];
  // With b inverted for subtraction, "same sign of a and b_op" is exactly the
  // differing-sign rule for SUB, so one expression covers both.
  assign add_ovf  = (a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    alu_res   = '0;
    alu_flags = '0;
    case (fc)
      F_AND:  alu_res = a & b;
      F_OR:   alu_res = a | b;
      F_XOR:  alu_res = a ^ b;
      F_ADD, F_SUB: begin
        alu_res         = sum;
        alu_flags.carry = sum_full[WIDTH];
        alu_flags.ovf   = add_ovf;
      end
      // Sign of the difference corrected by overflow gives the signed compare.
      F_SLT:  alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
      // No carry out of a + ~b + 1 means a borrow, i.e. a < b unsigned.
      F_SLTU: alu_res = {{(WIDTH-1){1'b0}}, ~sum_full[WIDTH]};
      // Code 011: illegal in the base build; with the multiplier compiled in
      // this single-cycle path is never loaded for it (mul_start wins).
      default: alu_flags.err = 1'b1;
    endcase
    alu_flags.zero = (alu_res == '0);
    alu_flags.neg  = alu_res[WIDTH-1];
  end

  // -------------------------------------------------------------- multiplier
`ifdef ALU_SEQ_MUL_EN
  assign mul_start = accept && (fc == F_MUL);

  alu_seq_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_p)
  );
`else
  assign mul_start = 1'b0;
  assign mul_done  = 1'b0;
  assign mul_p     = '0;
`endif

  // ------------------------------------------------------- FSM: next state
  always_comb begin
    state_d = state_q;
`ifdef ALU_SEQ_MUL_EN
    case (state_q)
      S_IDLE:     if (mul_start) state_d = S_MUL_BUSY;
      S_MUL_BUSY: if (mul_done)  state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
`else
    state_d = S_IDLE;
`endif
  end

  // ------------------------------------------------------- FSM: outputs
  // rdy_arm_q keeps in_ready low until the first clock after reset release.
  always_comb begin
    in_ready = rdy_arm_q && (state_q == S_IDLE) && (!out_valid_q || out_ready);
  end

  // ------------------------------------------------- output register next
  always_comb begin
    rdy_arm_d   = 1'b1;
    out_d       = out_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (accept && !mul_start) begin
      out_d       = alu_res;
      flags_d     = alu_flags;
      out_valid_d = 1'b1;
    end else if (mul_done) begin
      out_d         = mul_p;
      flags_d       = '0;
      flags_d.zero  = (mul_p == '0);
      flags_d.neg   = mul_p[WIDTH-1];
      out_valid_d   = 1'b1;
    end
  end

  // ------------------------------------------------------- state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rdy_arm_q   <= 1'b0;
      out_q       <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdy_arm_q   <= rdy_arm_d;
      out_q       <= out_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign zero      = flags_q.zero;
  assign neg       = flags_q.neg;
  assign carry     = flags_q.carry;
  assign ovf       = flags_q.ovf;
  assign err       = flags_q.err;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Self-checking bench for alu_seq (WIDTH=32); with
//               ALU_SEQ_MUL_EN defined a second WIDTH=8 instance exercises
//               the iterative multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, out;
  logic [2:0]  f;
  logic        zero, neg, carry, ovf, err;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] out;
    logic zero, neg, carry, ovf, err;
  } res_t;

  res_t sb[$];

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .f(f), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zero(zero), .neg(neg), .carry(carry), .ovf(ovf), .err(err)
  );

`ifdef ALU_SEQ_MUL_EN
  logic       m_in_valid, m_in_ready, m_out_valid, m_out_ready;
  logic [7:0] m_a, m_b, m_out;
  logic [2:0] m_f;
  logic       m_zero, m_neg, m_carry, m_ovf, m_err;

  alu_seq #(.WIDTH(8)) u_mul8 (
    .clk(clk), .rst_n(rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .a(m_a), .b(m_b), .f(m_f), .out_valid(m_out_valid), .out_ready(m_out_ready),
    .out(m_out), .zero(m_zero), .neg(m_neg), .carry(m_carry), .ovf(m_ovf), .err(m_err)
  );
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t dut_res();
    return {out, zero, neg, carry, ovf, err};
  endfunction

  // Reference: exact integer arithmetic, then reduced to 32 bits.
  function automatic res_t model(input logic [2:0] ff, input logic [31:0] x, input logic [31:0] y);
    res_t        m;
    longint      sx, sy, exact;
    logic [32:0] u;
    m  = '0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (ff)
      3'b000: m.out = x & y;
      3'b001: m.out = x | y;
      3'b100: m.out = x ^ y;
      3'b010: begin
        u       = {1'b0, x} + {1'b0, y};
        m.out   = u[31:0];
        m.carry = u[32];
        exact   = sx + sy;
        m.ovf   = (exact != longint'($signed(m.out)));
      end
      3'b110: begin
        m.out   = x - y;
        m.carry = (x >= y);
        exact   = sx - sy;
        m.ovf   = (exact != longint'($signed(m.out)));
      end
      3'b101: m.out = (x < y) ? 32'd1 : 32'd0;
      3'b111: m.out = (sx < sy) ? 32'd1 : 32'd0;
      default: begin
`ifdef ALU_SEQ_MUL_EN
        m.out = x * y;
`else
        m.err = 1'b1;
`endif
      end
    endcase
    m.zero = (m.out == 32'd0);
    m.neg  = m.out[31];
    return m;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 3))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  // Present one op at a negedge, wait (bounded) for in_ready, return #1
  // after the accepting edge.
  task automatic send(input logic [2:0] ff, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    in_valid = 1'b1; f = ff; a = x; b = y;
    #1;
    for (int i = 0; i < 50 && in_ready !== 1'b1; i++) @(negedge clk);
    if (in_ready !== 1'b1) chk("send_ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

`ifdef ALU_SEQ_MUL_EN
  task automatic mul8(input string tag, input logic [7:0] x, input logic [7:0] y);
    logic [15:0] full;
    logic [7:0]  p;
    full = 16'(x) * 16'(y);
    p    = full[7:0];
    @(negedge clk);
    m_in_valid = 1'b1; m_f = 3'b011; m_a = x; m_b = y; m_out_ready = 1'b1;
    #1;
    chk({tag, "_ready_pre"}, 64'(m_in_ready), 64'd1);
    @(posedge clk);
    #1;
    m_in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k != 0) begin @(posedge clk); #1; end
      chk({tag, "_busy_valid"}, 64'(m_out_valid), 64'd0);
      chk({tag, "_busy_ready"}, 64'(m_in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, 64'(m_out_valid), 64'd1);
    chk({tag, "_res"}, {m_out, m_zero, m_neg, m_carry, m_ovf, m_err},
        {p, (p == 8'd0), p[7], 1'b0, 1'b0, 1'b0});
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_valid, exp_ready;
    logic [2:0] rf;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; f = '0;
`ifdef ALU_SEQ_MUL_EN
    m_in_valid = 1'b0; m_out_ready = 1'b1; m_a = '0; m_b = '0; m_f = '0;
`endif
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_flags", 64'(dut_res()), 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_before_first_clk", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("ready_after_first_clk", 64'(in_ready), 64'd1);

    // Directed single-cycle ops
    send(3'b010, 32'h7FFF_FFFF, 32'h0000_0001);
    chk("add_ovf_valid", 64'(out_valid), 64'd1);
    chk("add_ovf", 64'(dut_res()), 64'(model(3'b010, 32'h7FFF_FFFF, 32'h1)));
    send(3'b110, 32'h0000_0000, 32'hFFFF_FFFF);
    chk("sub_borrow", 64'(dut_res()), 64'(model(3'b110, 32'h0, 32'hFFFF_FFFF)));
    send(3'b111, 32'h8000_0000, 32'h0000_0001);
    chk("slt_neg", 64'(dut_res()), 64'(model(3'b111, 32'h8000_0000, 32'h1)));
    send(3'b101, 32'h8000_0000, 32'h0000_0001);
    chk("sltu", 64'(dut_res()), 64'(model(3'b101, 32'h8000_0000, 32'h1)));
    send(3'b111, 32'h7FFF_FFFF, 32'h8000_0000);
    chk("slt_ovf", 64'(dut_res()), 64'(model(3'b111, 32'h7FFF_FFFF, 32'h8000_0000)));
`ifndef ALU_SEQ_MUL_EN
    send(3'b011, 32'h1234_5678, 32'h0000_0003);
    chk("illegal_valid", 64'(out_valid), 64'd1);
    chk("illegal", 64'(dut_res()), 64'(model(3'b011, 32'h1234_5678, 32'h3)));
`endif

    // Backpressure: held result, then handshake and new accept on one edge
    drain();
    out_ready = 1'b0;
    send(3'b000, 32'h1234_5678, 32'h8765_4321);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_hold", 64'(dut_res()), 64'(model(3'b000, 32'h1234_5678, 32'h8765_4321)));
      chk("bp_ready", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    in_valid = 1'b1; f = 3'b001; a = 32'h1234_5678; b = 32'h8765_4321; out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_swap_valid", 64'(out_valid), 64'd1);
    chk("bp_swap_res", 64'(dut_res()), 64'(model(3'b001, 32'h1234_5678, 32'h8765_4321)));
    @(posedge clk);
    #1;
    chk("bp_drop_valid", 64'(out_valid), 64'd0);

    // Random stream against a queue scoreboard: 20 back-to-back, then random
    // valid/ready, then a short drain.
    sb.delete();
    for (int c = 0; c < 52; c++) begin
      @(negedge clk);
      rf = 3'($urandom_range(0, 7));
`ifdef ALU_SEQ_MUL_EN
      if (rf == 3'b011) rf = 3'b010;
`endif
      f = rf; a = pick(); b = pick();
      if (c < 20)      begin in_valid = 1'b1; out_ready = 1'b1; end
      else if (c < 50) begin in_valid = 1'($urandom_range(0, 1)); out_ready = 1'($urandom_range(0, 1)); end
      else             begin in_valid = 1'b0; out_ready = 1'b1; end
      #1;
      exp_valid = (sb.size() != 0);
      exp_ready = !exp_valid || out_ready;
      chk("sb_valid", 64'(out_valid), 64'(exp_valid));
      chk("sb_ready", 64'(in_ready), 64'(exp_ready));
      if (exp_valid) chk("sb_result", 64'(dut_res()), 64'(sb[0]));
      @(posedge clk);
      if (exp_valid && out_ready) void'(sb.pop_front());
      if (in_valid && exp_ready) sb.push_back(model(f, a, b));
    end
    in_valid = 1'b0;

    // Reset while an unconsumed result is held
    drain();
    out_ready = 1'b0;
    send(3'b010, 32'h0000_0005, 32'h0000_0006);
    chk("hold_before_reset", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_out", 64'(dut_res()), 64'd0);
    chk("async_reset_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("no_stale_after_reset", 64'(out_valid), 64'd0);
    end

`ifdef ALU_SEQ_MUL_EN
    mul8("mul_0f_11", 8'h0F, 8'h11);
    @(negedge clk);
    mul8("mul_10_10", 8'h10, 8'h10);
    @(negedge clk);
    mul8("mul_rand", 8'($urandom), 8'($urandom));
    // Reset during the third cycle of a multiply
    @(negedge clk);
    m_in_valid = 1'b1; m_f = 3'b011; m_a = 8'h0B; m_b = 8'h0D;
    @(posedge clk);
    #1;
    m_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mulrst_valid", 64'(m_out_valid), 64'd0);
    chk("mulrst_out", {m_out, m_zero, m_neg, m_carry, m_ovf, m_err}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mulrst_ready_pre", 64'(m_in_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("mulrst_ready_post", 64'(m_in_ready), 64'd1);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      chk("mulrst_no_stale", 64'(m_out_valid), 64'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
